chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
Multi-cycle parametrised adder/subtractor. It processes W bits of two N-bit operands per clock, LSB chunk first, and carries the chunk carry between cycles in a register. Operands enter and the result leaves through valid/ready handshakes. It is the area-lean successor of the combinational ripple adder, for datapaths that trade latency for fewer full-adder cells. The result format stays N+1 bits with the carry-out as the MSB.

Parameters:
N, 8, operand width in bits; must be ≥1.
W, 2, bits processed per cycle; must divide N exactly. CHUNKS = N/W. W=N gives single-chunk operation; W=1 is bit-serial.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode are valid
in_ready  output  1  block can accept an operation
num1  input  N  operand A
num2  input  N  operand B
sub  input  1  0 = A+B, 1 = A−B (computed as A + ~B + 1)
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
result  output  N+1  {carry_out, sum[N-1:0]}
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the clk rising edge. It has priority over all other inputs. It forces state IDLE, the chunk counter to 0, result to 0, out_valid to 0, busy to 0 and in_ready to 1. Reset during RUN or DONE discards the operation, and no out_valid follows.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, register num1, num2 (inverted if sub=1) and sub.
  - Initialise the carry register to sub and the counter to 0, then go to RUN.
- RUN:
  - in_ready=0; in_valid, num1, num2 and sub are ignored.
  - Each edge adds chunk k (bits k·W+W−1 … k·W) of both registered operands plus the carry register.
  - It writes the W sum bits into result[k·W+W−1 : k·W], updates the carry register with the chunk carry-out, and increments k.
  - On the edge that processes chunk CHUNKS−1, it writes result[N] = final carry and goes to DONE.
- DONE:
  - out_valid=1 and result is stable.
  - It stays in DONE while out_ready=0, with result and out_valid held.
  - On an edge with out_ready=1, it goes to IDLE and clears out_valid. result keeps its last value.
- Latency: for an acceptance edge T, out_valid is high after edge T+CHUNKS, i.e. CHUNKS cycles later.
  - Throughput is one operation per CHUNKS+2 cycles minimum: acceptance, then CHUNKS RUN edges, then the DONE handshake edge.
  - There is no overlap. in_ready is 0 in RUN and DONE, including the cycle where out_ready=1.
- Arithmetic:
  - Unsigned modulo 2^N sum in result[N-1:0].
  - For add, result[N] is the carry-out.
  - For sub, result[N]=1 iff num1 ≥ num2 unsigned (i.e. no borrow).
- Partial result bits written during RUN are visible on result but are not valid until out_valid=1.
- Inputs change freely whenever in_ready=0 or in_valid=0, with no effect on the block.

Optional Feature:
CSA_SIGNED_OVF_EN. When the macro is defined, an extra output port ovf (1 bit) is added.
- On entering DONE, ovf is set to the two's-complement overflow: the carry into the MSB XOR the carry out of the MSB. This is computed in the final chunk.
- ovf is held with result, and reset clears it to 0.

When the macro is undefined, the ovf port and its logic do not exist, and there is no other behavioural change.

Test Plan:
(N=8, W=2 unless noted)
1. Add: in_valid=1, num1=200, num2=100, sub=0 → in_ready drops, out_valid rises exactly 4 cycles after acceptance, result=9'h12C; with out_ready=1 it returns to IDLE with in_ready=1 on the next cycle.
2. Max add and subtract: 255+255 → 9'h1FE. 7−5 → 9'h102 (no borrow). 5−7 → 9'h0FE (borrow, MSB=0).
3. Back-pressure: hold out_ready=0 for 3 cycles after out_valid with in_valid=1 and changing operands → result and out_valid stay constant, no new operation is accepted, and in_ready stays 0 until after the release edge.
4. Reset mid-operation: assert rst for 1 cycle during the 2nd RUN cycle → the next cycle shows in_ready=1, out_valid=0, busy=0, result=0; a following 1+1 gives result=9'h002.
5. Width sweep with W=1 and W=8 (N=8) → 200+100 gives result 9'h12C with out_valid after 8 cycles and 1 cycle respectively.
6. With CSA_SIGNED_OVF_EN defined: 127+1 → result=9'h080, ovf=1. 0−1 → result=9'h0FF, ovf=0. (−128)−1 → ovf=1.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
// Defining CSA_SIGNED_OVF_EN adds the ovf signal.
interface chunked_serial_adder_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num1;
    logic [N-1:0] num2;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   result;
    logic         busy;
`ifdef CSA_SIGNED_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, num1, num2, sub, out_ready,
`ifdef CSA_SIGNED_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, num1, num2, sub, out_ready,
`ifdef CSA_SIGNED_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: W bits per clock, LSB chunk first, carry held between cycles.
// Optional CSA_SIGNED_OVF_EN macro adds a two's-complement overflow flag (ovf).
module chunked_serial_adder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 2
) (
    input logic                   clk,
    input logic                   rst,
    chunked_serial_adder_if.slave bus
);
    localparam int unsigned Chunks = N / W;
    localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N:0]      res_q, res_d;
    logic [W:0]      chunk_sum;
    logic            last_chunk;

    // Operands shift right each RUN cycle so the live chunk is always in the low W bits.
    assign chunk_sum  = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};
    assign last_chunk = (cnt_q == CntW'(Chunks - 1));

`ifdef CSA_SIGNED_OVF_EN
    logic ovf_q, ovf_d;
    logic msb_cin;
    assign msb_cin = a_q[W-1] ^ b_q[W-1] ^ chunk_sum[W-1];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef CSA_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.num1;
                    b_d     = bus.sub ? ~bus.num2 : bus.num2;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                carry_d = chunk_sum[W];
                for (int unsigned k = 0; k < Chunks; k++) begin
                    if (cnt_q == CntW'(k)) res_d[k*W +: W] = chunk_sum[W-1:0];
                end
                if (last_chunk) begin
                    res_d[N] = chunk_sum[W];
`ifdef CSA_SIGNED_OVF_EN
                    ovf_d    = msb_cin ^ chunk_sum[W];
`endif
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
`ifdef CSA_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef CSA_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = res_q;
`ifdef CSA_SIGNED_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: W=2 main instance plus W=1 and W=8 latency sweep.
// Define CSA_SIGNED_OVF_EN to also check the overflow flag.
module tb_chunked_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chunked_serial_adder_if #(.N(8)) if2 ();
  chunked_serial_adder_if #(.N(8)) if1 ();
  chunked_serial_adder_if #(.N(8)) if8 ();

  chunked_serial_adder #(.N(8), .W(2)) u_w2 (.clk(clk), .rst(rst), .bus(if2));
  chunked_serial_adder #(.N(8), .W(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
  chunked_serial_adder #(.N(8), .W(8)) u_w8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the W=2 instance, check result once out_valid rises, then release it.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [8:0] exp_res, input logic exp_ovf, input string tag);
    int n = 0;
    if2.num1 = a; if2.num2 = b; if2.sub = s; if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    while (!if2.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, if2.out_valid === 1'b1);
    chk({tag, "_result"}, if2.result === exp_res);
`ifdef CSA_SIGNED_OVF_EN
    chk({tag, "_ovf"}, if2.ovf === exp_ovf);
`else
    if (exp_ovf) begin end
`endif
    if2.out_ready = 1'b1;
    tick();
    if2.out_ready = 1'b0;
  endtask

  // Run 200+100 on a sweep instance and measure acceptance-to-out_valid latency.
  task automatic sweep_w1(output int lat, output logic [8:0] res);
    lat = 0;
    if1.num1 = 8'd200; if1.num2 = 8'd100; if1.sub = 1'b0; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    while (!if1.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = if1.result;
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
  endtask

  task automatic sweep_w8(output int lat, output logic [8:0] res);
    lat = 0;
    if8.num1 = 8'd200; if8.num2 = 8'd100; if8.sub = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    while (!if8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = if8.result;
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [8:0] res;
    logic       saw_valid;

    if2.in_valid = 0; if2.num1 = 0; if2.num2 = 0; if2.sub = 0; if2.out_ready = 0;
    if1.in_valid = 0; if1.num1 = 0; if1.num2 = 0; if1.sub = 0; if1.out_ready = 0;
    if8.in_valid = 0; if8.num1 = 0; if8.num2 = 0; if8.sub = 0; if8.out_ready = 0;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", if2.in_ready === 1'b1);
    chk("rst_out_valid", if2.out_valid === 1'b0);
    chk("rst_busy", if2.busy === 1'b0);
    chk("rst_result", if2.result === 9'h000);

    // Basic add with exact latency.
    if2.num1 = 8'd200; if2.num2 = 8'd100; if2.sub = 1'b0; if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    chk("add_in_ready_drop", if2.in_ready === 1'b0);
    chk("add_busy", if2.busy === 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk("add_early_valid", if2.out_valid === 1'b0);
      tick();
    end
    chk("add_valid_still_low_t3", if2.out_valid === 1'b0);
    tick();
    chk("add_valid_t4", if2.out_valid === 1'b1);
    chk("add_result", if2.result === 9'h12C);
    chk("add_done_in_ready", if2.in_ready === 1'b0);
    if2.out_ready = 1'b1;
    chk("add_release_in_ready", if2.in_ready === 1'b0);
    tick();
    if2.out_ready = 1'b0;
    chk("add_idle_in_ready", if2.in_ready === 1'b1);
    chk("add_idle_out_valid", if2.out_valid === 1'b0);
    chk("add_idle_result_held", if2.result === 9'h12C);

    // Boundary arithmetic.
    do_op(8'd255, 8'd255, 1'b0, 9'h1FE, 1'b0, "max_add");
    do_op(8'd7, 8'd5, 1'b1, 9'h102, 1'b0, "sub_noborrow");
    do_op(8'd5, 8'd7, 1'b1, 9'h0FE, 1'b0, "sub_borrow");

    // Back-pressure with new operands offered.
    if2.num1 = 8'd10; if2.num2 = 8'd20; if2.sub = 1'b0; if2.in_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if2.num1 = 8'(i * 37 + 3);
      tick();
    end
    chk("bp_valid", if2.out_valid === 1'b1);
    for (int i = 0; i < 3; i++) begin
      if2.num1 = 8'(i * 91 + 11);
      if2.num2 = 8'(i + 1);
      if2.sub  = 1'(i);
      tick();
      chk("bp_hold_valid", if2.out_valid === 1'b1);
      chk("bp_hold_result", if2.result === 9'h01E);
      chk("bp_hold_in_ready", if2.in_ready === 1'b0);
    end
    if2.out_ready = 1'b1;
    chk("bp_release_in_ready", if2.in_ready === 1'b0);
    tick();
    if2.out_ready = 1'b0;
    if2.in_valid  = 1'b0;
    chk("bp_after_in_ready", if2.in_ready === 1'b1);
    chk("bp_after_valid", if2.out_valid === 1'b0);

    // Reset during the second RUN cycle.
    if2.num1 = 8'd200; if2.num2 = 8'd100; if2.sub = 1'b0; if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", if2.in_ready === 1'b1);
    chk("mrst_out_valid", if2.out_valid === 1'b0);
    chk("mrst_busy", if2.busy === 1'b0);
    chk("mrst_result", if2.result === 9'h000);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_valid |= if2.out_valid;
    end
    chk("mrst_no_stale_valid", saw_valid === 1'b0);
    do_op(8'd1, 8'd1, 1'b0, 9'h002, 1'b0, "post_rst_add");

    // Width sweep.
    sweep_w1(lat, res);
    chk("w1_latency", lat == 8);
    chk("w1_result", res === 9'h12C);
    sweep_w8(lat, res);
    chk("w8_latency", lat == 1);
    chk("w8_result", res === 9'h12C);

`ifdef CSA_SIGNED_OVF_EN
    do_op(8'd127, 8'd1, 1'b0, 9'h080, 1'b1, "ovf_pos");
    do_op(8'd0, 8'd1, 1'b1, 9'h0FF, 1'b0, "ovf_zero_minus_one");
    do_op(8'h80, 8'd1, 1'b1, 9'h17F, 1'b1, "ovf_neg");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_rst", if2.ovf === 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
